// File: rtl/board_stream_decoder.sv
// -----------------------------------------------------------------------------
// board_stream_decoder
//
// Purpose:
//   Decodes a terminal-style byte stream into a WIDTH x HEIGHT board of cells.
//   A frame is the cursor-home sequence ESC '[' ';' 'H' followed by one byte per
//   cell ('O' = alive, ' ' = dead), optionally broken into rows by CR/LF.
//   Anything outside a frame (banner text, trailing CR/LF) is skipped silently.
//   A malformed frame raises a one-cycle frame_error and the board keeps its
//   previous contents.
//
// Handshake:
//   A byte is consumed on a rising edge where rx_valid and rx_ready are both 1.
//   rx_valid may stay high across cycles where rx_ready is 0; the byte is simply
//   held by the producer until a cycle with rx_ready=1.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   rx_data      in   [7:0] received byte
//   rx_valid     in   rx_data holds an unconsumed byte
//   rx_ready     out  decoder can consume a byte this cycle (registered)
//   board        out  [WIDTH*HEIGHT-1:0] last complete frame, bit r*WIDTH+c = cell (c,r)
//   board_valid  out  one-cycle pulse when board updates
//   alive_count  out  number of set bits in board
//   frame_count  out  [7:0] completed frames, wraps 255 -> 0
//   frame_error  out  one-cycle pulse on a protocol violation
//   dbg_state_o  out  [2:0] current decoder state (debug visibility)
// -----------------------------------------------------------------------------
module board_stream_decoder #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    localparam int CELLS = WIDTH * HEIGHT,
    localparam int IDX_W = $clog2(CELLS),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [CELLS-1:0] board,
    output logic             board_valid,
    output logic [CNT_W-1:0] alive_count,
    output logic [7:0]       frame_count,
    output logic             frame_error,
    output logic [2:0]       dbg_state_o
);

    localparam logic [7:0] BYTE_ESC   = 8'h1B;
    localparam logic [7:0] BYTE_LBRK  = 8'h5B;
    localparam logic [7:0] BYTE_SEMI  = 8'h3B;
    localparam logic [7:0] BYTE_H     = 8'h48;
    localparam logic [7:0] BYTE_ALIVE = 8'h4F;
    localparam logic [7:0] BYTE_DEAD  = 8'h20;
    localparam logic [7:0] BYTE_CR    = 8'h0D;
    localparam logic [7:0] BYTE_LF    = 8'h0A;

    localparam logic [IDX_W-1:0] COL_MASK  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(CELLS - 1);

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        ESC1 = 3'd1,
        ESC2 = 3'd2,
        ESC3 = 3'd3,
        CELL = 3'd4,
        EMIT = 3'd5
    } state_e;

    state_e             state_q;
    logic               rx_ready_q;
    logic [CELLS-1:0]   shadow_q;
    logic [CELLS-1:0]   board_q;
    logic [IDX_W-1:0]   cell_idx_q;
    logic [CNT_W-1:0]   shadow_cnt_q;
    logic [CNT_W-1:0]   alive_q;
    logic [7:0]         frame_cnt_q;
    logic               board_valid_q;
    logic               frame_error_q;

    // Byte classification of the current input
    logic consume;
    logic is_alive;
    logic is_dead;
    logic is_cell;
    logic is_eol;
    logic at_row_start;
    logic at_last_cell;

    // Next-values used when a cell byte is written
    logic [CELLS-1:0] shadow_d;
    logic [CNT_W-1:0] shadow_cnt_d;
    logic [IDX_W-1:0] cell_idx_d;
    state_e           err_state_d;

    assign consume  = rx_valid && rx_ready_q;
    assign is_alive = (rx_data == BYTE_ALIVE);
    assign is_dead  = (rx_data == BYTE_DEAD);
    assign is_cell  = is_alive || is_dead;
    assign is_eol   = (rx_data == BYTE_CR) || (rx_data == BYTE_LF);

    // CR/LF only makes sense between rows: column 0 of a row other than the first.
    assign at_row_start = ((cell_idx_q & COL_MASK) == '0) && (cell_idx_q != '0);
    assign at_last_cell = (cell_idx_q == LAST_CELL);

    assign shadow_cnt_d = shadow_cnt_q + CNT_W'(is_alive);
    assign cell_idx_d   = cell_idx_q + IDX_W'(1);

    // An ESC that breaks a frame is itself the start of a new header.
    assign err_state_d  = (rx_data == BYTE_ESC) ? ESC1 : HUNT;

    always_comb begin
        shadow_d             = shadow_q;
        shadow_d[cell_idx_q] = is_alive;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            rx_ready_q    <= 1'b0;
            shadow_q      <= '0;
            board_q       <= '0;
            cell_idx_q    <= '0;
            shadow_cnt_q  <= '0;
            alive_q       <= '0;
            frame_cnt_q   <= '0;
            board_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            // Pulses last one cycle; ready is high everywhere except EMIT.
            board_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            rx_ready_q    <= 1'b1;

            case (state_q)
                HUNT: begin
                    if (consume && (rx_data == BYTE_ESC)) begin
                        state_q <= ESC1;
                    end
                end

                ESC1: begin
                    if (consume) begin
                        if (rx_data == BYTE_LBRK) begin
                            state_q <= ESC2;
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= err_state_d;
                        end
                    end
                end

                ESC2: begin
                    if (consume) begin
                        if (rx_data == BYTE_SEMI) begin
                            state_q <= ESC3;
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= err_state_d;
                        end
                    end
                end

                ESC3: begin
                    if (consume) begin
                        if (rx_data == BYTE_H) begin
                            state_q      <= CELL;
                            cell_idx_q   <= '0;
                            shadow_cnt_q <= '0;
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= err_state_d;
                        end
                    end
                end

                CELL: begin
                    if (consume) begin
                        if (is_cell) begin
                            shadow_q     <= shadow_d;
                            shadow_cnt_q <= shadow_cnt_d;
                            if (at_last_cell) begin
                                // Publish on this edge so board_valid is high
                                // during EMIT together with the new board.
                                board_q       <= shadow_d;
                                alive_q       <= shadow_cnt_d;
                                frame_cnt_q   <= frame_cnt_q + 8'd1;
                                board_valid_q <= 1'b1;
                                rx_ready_q    <= 1'b0;
                                state_q       <= EMIT;
                            end else begin
                                cell_idx_q <= cell_idx_d;
                            end
                        end else if (is_eol && at_row_start) begin
                            // Optional row terminator: consumed, no effect.
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= err_state_d;
                        end
                    end
                end

                EMIT: begin
                    state_q <= HUNT;
                end

                default: begin
                    state_q <= HUNT;
                end
            endcase
        end
    end

    assign rx_ready    = rx_ready_q;
    assign board       = board_q;
    assign board_valid = board_valid_q;
    assign alive_count = alive_q;
    assign frame_count = frame_cnt_q;
    assign frame_error = frame_error_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/board_stream_decoder.md
BOARD_STREAM_DECODER -- requirements
Module: board_stream_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning board columns (power of two).
REQ-002 SHALL have parameter HEIGHT, default 8, meaning board rows (power of two).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port rx_data, input, 8, meaning the received UART byte.
REQ-006 SHALL have port rx_valid, input, 1, meaning rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready, output, 1, meaning the decoder can consume a byte this cycle.
REQ-008 SHALL have port board, output, WIDTH*HEIGHT, meaning the last complete frame; bit r*WIDTH+c is cell (c,r).
REQ-009 SHALL have port board_valid, output, 1, meaning a one-cycle pulse when board updates.
REQ-010 SHALL have port alive_count, output, log2(WIDTH*HEIGHT)+1, meaning the number of set bits in board.
REQ-011 SHALL have port frame_count, output, 8, meaning the number of completed frames, wrapping 255->0.
REQ-012 SHALL have port frame_error, output, 1, meaning a one-cycle pulse on a protocol violation.

Function
REQ-013 SHALL consume a byte only on a cycle where rx_valid=1 and rx_ready=1.
REQ-014 SHALL drive rx_ready as a registered signal, high in every state except EMIT.
REQ-015 SHALL implement these states: HUNT, ESC1, ESC2, ESC3, CELL, EMIT.
REQ-016 HUNT: byte 0x1B goes to ESC1; any other byte is discarded silently, including the banner text and without raising frame_error.
REQ-017 ESC1 requires 0x5B ('['), ESC2 requires 0x3B (';') and ESC3 requires 0x48 ('H'); each expected byte advances one state, and ESC3 enters CELL with the cell index cleared to 0 and the shadow count cleared to 0.
REQ-018 CELL: byte 0x4F ('O') writes 1 and byte 0x20 (space) writes 0 into shadow[cell index]; the cell index then increments and the shadow count adds the written bit.
REQ-019 CELL: bytes 0x0D and 0x0A SHALL be consumed with no effect only when the column (cell index mod WIDTH) is 0 and the cell index is nonzero; they are optional row terminators.
REQ-020 CELL: the byte that writes cell WIDTH*HEIGHT-1 SHALL move the decoder to EMIT; a trailing CR/LF afterwards is discarded in HUNT.
REQ-021 EMIT (exactly one cycle) SHALL copy shadow into board, the shadow count into alive_count, pulse board_valid, increment frame_count and go to HUNT.
REQ-022 board_valid SHALL be high on the cycle after the final cell byte is consumed; board, alive_count and frame_count SHALL change on that same edge.
REQ-023 Any unexpected byte in ESC1, ESC2, ESC3 or CELL SHALL pulse frame_error on the next cycle and leave board unchanged.
REQ-024 After an unexpected byte, the decoder goes to ESC1 if that byte is 0x1B and to HUNT otherwise.
REQ-025 0x1B received in CELL is a violation per REQ-023 and restarts the header per REQ-024.
REQ-026 The cell index SHALL be log2(WIDTH*HEIGHT) bits and SHALL NOT wrap within a frame, because EMIT precedes the wrap.
REQ-027 The shadow count SHALL be log2(WIDTH*HEIGHT)+1 bits so that an all-alive board gives 64 with no overflow.
REQ-028 board_valid and frame_error SHALL never be asserted on the same cycle.

Reset
REQ-029 While rst_n=0, the decoder SHALL be in HUNT with rx_ready=0, board=0, shadow=0, alive_count=0, frame_count=0, board_valid=0, frame_error=0 and cell index=0.
REQ-030 rx_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; the next frame requires a full ESC [ ; H header.

Verification
REQ-032 Stimulus: 1B 5B 3B 48, then 64 bytes alternating 4F,20. Response: board=0x5555555555555555, alive_count=32, frame_count=1, one board_valid pulse.
REQ-033 Stimulus: 57 arbitrary banner bytes without 0x1B, then header and 64x 0x20, with CR LF after every 8 cells. Response: board=0, alive_count=0, no frame_error.
REQ-034 Stimulus: header, 10 cells, then 0x41. Response: one frame_error pulse, board unchanged, decoder in HUNT, next valid frame accepted.
REQ-035 Stimulus: header, 20 cells, then 1B 5B 3B 48 and 64x 4F. Response: one frame_error pulse, then board=all ones and alive_count=64.
REQ-036 Stimulus: CR at column 3. Response: frame_error pulse. Stimulus: rx_valid held high across EMIT. Response: rx_ready=0 for one cycle and no byte lost.
REQ-037 Stimulus: 256 valid frames, then rst_n pulsed low mid-frame. Response: frame_count wraps to 0 after the 256th frame, and all outputs return to their reset values asynchronously.
